// File: rtl/atmega_eep_xfer.sv
// -----------------------------------------------------------------------------
// atmega_eep_xfer
// Initiator on the ATmega EEPROM external access port. Streams a complete
// EEPROM image in from a byte source (load) or out to a byte sink (dump), and
// holds the CPU off the EEPROM registers while a transfer is in progress.
//
// Parameters
//   EEP_SIZE   bytes per load/dump (2..131072)
//   AUTO_DUMP  1: start a dump on a rising edge of content_modified while idle
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   load_start/dump_start      one-cycle start pulses (load wins a tie)
//   abort                      one-cycle pulse, drops any transfer, no done
//   busy, done, byte_cnt       status: in progress, completion pulse, count
//   cpu_hold                   CPU must keep off the EEPROM while high
//   content_modified           modified flag from the EEPROM block
//   s_data/s_valid/s_ready     load stream (sink side)
//   m_data/m_valid/m_ready     dump stream (source side)
//   ext_eep_*                  EEPROM external access port
// -----------------------------------------------------------------------------
module atmega_eep_xfer #(
    parameter int unsigned EEP_SIZE  = 512,
    parameter bit          AUTO_DUMP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        dump_start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [16:0] byte_cnt,
    output logic        cpu_hold,
    input  logic        content_modified,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [16:0] ext_eep_addr,
    output logic [7:0]  ext_eep_data_out,
    output logic        ext_eep_data_wr,
    input  logic [7:0]  ext_eep_data_in,
    output logic        ext_eep_data_rd,
    output logic        ext_eep_data_en
);

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 8;
    // One extra bit so a count equal to 131072 is still representable.
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(EEP_SIZE);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_LOAD_WR  = 3'd2,
        S_DUMP_RD  = 3'd3,
        S_DUMP_CAP = 3'd4,
        S_DUMP_OUT = 3'd5,
        S_FIN      = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W-1:0]   mdata_q, mdata_d;
    logic                cm_q;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                s_ready_q, s_ready_d;
    logic                m_valid_q, m_valid_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic                cm_edge;

    // Rising edge of content_modified; only acted on in IDLE, so edges seen
    // during a transfer are dropped rather than queued.
    assign cm_edge = AUTO_DUMP && content_modified && !cm_q;

    // Next state, counters and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        mdata_d = mdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    addr_d  = '0;
                end else if (dump_start || cm_edge) begin
                    state_d = S_DUMP_RD;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            S_LOAD: begin
                if (s_valid && s_ready_q) begin
                    dout_d  = s_data;
                    state_d = S_LOAD_WR;
                end
            end
            S_LOAD_WR: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_d == SIZE_C) ? S_FIN : S_LOAD;
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                // EEPROM read data is valid the cycle after the read request.
                mdata_d = ext_eep_data_in;
                state_d = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (m_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_d == SIZE_C) ? S_FIN : S_DUMP_RD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition; a write already on the port completes.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        // The address follows the count only when a new access is issued, so
        // it never shows EEP_SIZE.
        if ((state_d == S_LOAD_WR) || (state_d == S_DUMP_RD)) begin
            addr_d = cnt_d[ADDR_W-1:0];
        end
    end

    // Output decode from the next state so every port comes straight off a flop.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
        s_ready_d = (state_d == S_LOAD);
        wr_d      = (state_d == S_LOAD_WR);
        rd_d      = (state_d == S_DUMP_RD) || (state_d == S_DUMP_CAP);
        m_valid_d = (state_d == S_DUMP_OUT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            mdata_q   <= '0;
            cm_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            mdata_q   <= mdata_d;
            cm_q      <= content_modified;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    assign busy             = busy_q;
    assign cpu_hold         = busy_q;
    assign ext_eep_data_en  = busy_q;
    assign done             = done_q;
    assign byte_cnt         = cnt_q[ADDR_W-1:0];
    assign s_ready          = s_ready_q;
    assign m_data           = mdata_q;
    assign m_valid          = m_valid_q;
    assign ext_eep_addr     = addr_q;
    assign ext_eep_data_out = dout_q;
    assign ext_eep_data_wr  = wr_q;
    assign ext_eep_data_rd  = rd_q;

endmodule

// File: tb/tb_atmega_eep_xfer.sv
// -----------------------------------------------------------------------------
// tb_atmega_eep_xfer
// Directed bench for atmega_eep_xfer (EEP_SIZE=8, AUTO_DUMP=1) with a small
// EEPROM read model, a byte source and logs of writes, dump bytes, done
// pulses and read cycles.
// -----------------------------------------------------------------------------
module tb_atmega_eep_xfer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, dump_start, abort;
    logic        busy, done, cpu_hold;
    logic [16:0] byte_cnt;
    logic        content_modified;
    logic [7:0]  s_data;
    logic        s_valid, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_ready;
    logic [16:0] ext_eep_addr;
    logic [7:0]  ext_eep_data_out;
    logic        ext_eep_data_wr;
    logic [7:0]  ext_eep_data_in;
    logic        ext_eep_data_rd;
    logic        ext_eep_data_en;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    atmega_eep_xfer #(.EEP_SIZE(8), .AUTO_DUMP(1'b1)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .load_start       (load_start),
        .dump_start       (dump_start),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .byte_cnt         (byte_cnt),
        .cpu_hold         (cpu_hold),
        .content_modified (content_modified),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .ext_eep_addr     (ext_eep_addr),
        .ext_eep_data_out (ext_eep_data_out),
        .ext_eep_data_wr  (ext_eep_data_wr),
        .ext_eep_data_in  (ext_eep_data_in),
        .ext_eep_data_rd  (ext_eep_data_rd),
        .ext_eep_data_en  (ext_eep_data_en)
    );

    always #5 clk = ~clk;

    // EEPROM model preloaded with 0xA0..0xA7; read data one cycle after rd.
    logic [7:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    always @(posedge clk) begin
        if (ext_eep_data_en && ext_eep_data_rd) ext_eep_data_in <= mem[ext_eep_addr[2:0]];
    end

    // Byte source: 0x10 + number of bytes accepted since hs_base.
    int unsigned hs_cnt = 0;
    int unsigned hs_base = 0;
    always @(posedge clk) if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
    assign s_data = 8'h10 + 8'(hs_cnt - hs_base);

    // Event logs sampled mid-cycle.
    int unsigned cyc = 0;
    int unsigned wr_addr[$], wr_data[$], wr_cyc[$];
    int unsigned md_data[$], md_cyc[$];
    int unsigned done_cnt = 0;
    int unsigned rd_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ext_eep_data_wr) begin
            wr_addr.push_back(32'(ext_eep_addr));
            wr_data.push_back(32'(ext_eep_data_out));
            wr_cyc.push_back(cyc);
        end
        if (m_valid && m_ready) begin
            md_data.push_back(32'(m_data));
            md_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (ext_eep_data_rd) rd_cnt <= rd_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        md_data.delete(); md_cyc.delete();
    endtask

    // Bounded wait for the done pulse; returns in the FIN cycle.
    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        int unsigned done0, rd0, rd_stall;

        rst = 1'b1; load_start = 1'b0; dump_start = 1'b0; abort = 1'b0;
        content_modified = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ctl", 32'({busy, done, cpu_hold, s_ready, m_valid, ext_eep_data_wr,
                            ext_eep_data_rd, ext_eep_data_en}), 32'h0);
        chk("rst_cnt", 32'(byte_cnt), 32'h0);
        chk("rst_addr", 32'(ext_eep_addr), 32'h0);

        // Load 8 bytes; simultaneous dump_start loses, later dump_start ignored
        clear_logs(); done0 = done_cnt; rd0 = rd_cnt;
        hs_base = hs_cnt; s_valid = 1'b1;
        load_start = 1'b1; dump_start = 1'b1;
        tick();
        load_start = 1'b0; dump_start = 1'b0;
        chk("load_sready", 32'(s_ready), 32'd1);
        tick(); tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wait_done("load_done");
        chk("load_busy_at_done", 32'(busy), 32'd1);
        tick();
        s_valid = 1'b0;
        chk("load_busy_after", 32'({busy, done}), 32'h0);
        chk("load_done_cnt", done_cnt - done0, 32'd1);
        chk("load_byte_cnt", 32'(byte_cnt), 32'd8);
        chk("load_wr_cnt", wr_addr.size(), 32'd8);
        for (int i = 0; i < wr_addr.size(); i++) begin
            chk("load_wr_addr", wr_addr[i], 32'(i));
            chk("load_wr_data", wr_data[i], 32'h10 + 32'(i));
            if (i > 0) chk("load_wr_gap", wr_cyc[i] - wr_cyc[i-1], 32'd2);
        end
        repeat (6) tick();
        chk("load_no_dump_busy", 32'(busy), 32'd0);
        chk("load_no_dump_rd", rd_cnt - rd0, 32'd0);
        chk("load_no_dump_bytes", md_data.size(), 32'd0);

        // Dump 8 bytes, m_ready always high
        clear_logs(); done0 = done_cnt; rd0 = rd_cnt;
        m_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("dump_rd_first", 32'({ext_eep_data_rd, ext_eep_data_en, cpu_hold}), 32'h7);
        wait_done("dump_done");
        tick();
        chk("dump_done_cnt", done_cnt - done0, 32'd1);
        chk("dump_rd_cycles", rd_cnt - rd0, 32'd16);
        chk("dump_byte_cnt", 32'(byte_cnt), 32'd8);
        chk("dump_nbytes", md_data.size(), 32'd8);
        for (int i = 0; i < md_data.size(); i++) begin
            chk("dump_data", md_data[i], 32'hA0 + 32'(i));
            if (i > 0) chk("dump_gap", md_cyc[i] - md_cyc[i-1], 32'd3);
        end

        // Dump with a 5-cycle stall on byte 2
        clear_logs(); done0 = done_cnt; rd0 = rd_cnt;
        m_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        n = 0;
        while (md_data.size() < 2 && n < 100) begin tick(); n++; end
        m_ready = 1'b0;
        chk("stall_pre_bytes", md_data.size(), 32'd2);
        n = 0;
        while (m_valid !== 1'b1 && n < 20) begin tick(); n++; end
        rd_stall = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'hA2);
            if (i < 4) tick();
        end
        chk("stall_no_rd", rd_cnt - rd_stall, 32'd0);
        m_ready = 1'b1;
        wait_done("stall_done");
        tick();
        chk("stall_nbytes", md_data.size(), 32'd8);
        for (int i = 0; i < md_data.size(); i++) chk("stall_order", md_data[i], 32'hA0 + 32'(i));
        chk("stall_rd_cycles", rd_cnt - rd0, 32'd16);
        chk("stall_done_cnt", done_cnt - done0, 32'd1);

        // Abort after 3 loaded bytes, then restart
        clear_logs(); done0 = done_cnt;
        hs_base = hs_cnt; s_valid = 1'b1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n = 0;
        while (wr_addr.size() < 3 && n < 100) begin tick(); n++; end
        s_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ctl", 32'({busy, ext_eep_data_en, s_ready, done}), 32'h0);
        chk("abort_byte_cnt", 32'(byte_cnt), 32'd3);
        repeat (3) tick();
        chk("abort_no_done", done_cnt - done0, 32'd0);
        chk("abort_wr_cnt", wr_addr.size(), 32'd3);
        clear_logs();
        hs_base = hs_cnt; s_valid = 1'b1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n = 0;
        while (wr_addr.size() < 1 && n < 20) begin tick(); n++; end
        chk("restart_nwr", wr_addr.size(), 32'd1);
        chk("restart_addr0", wr_addr.size() > 0 ? wr_addr[0] : 32'hFFFF_FFFF, 32'd0);
        chk("restart_data0", wr_data.size() > 0 ? wr_data[0] : 32'hFFFF_FFFF, 32'h10);
        wait_done("restart_done");
        tick();
        s_valid = 1'b0;
        chk("restart_byte_cnt", 32'(byte_cnt), 32'd8);

        // Auto dump on content_modified rising edge
        clear_logs(); done0 = done_cnt;
        m_ready = 1'b1;
        content_modified = 1'b1;
        tick();
        chk("auto_start", 32'({busy, ext_eep_data_rd}), 32'h3);
        wait_done("auto_done");
        tick();
        chk("auto_nbytes", md_data.size(), 32'd8);
        chk("auto_last", md_data.size() > 0 ? md_data[md_data.size()-1] : 32'hFFFF_FFFF, 32'hA7);
        repeat (10) tick();
        chk("auto_no_second", 32'(busy), 32'd0);
        chk("auto_done_cnt", done_cnt - done0, 32'd1);

        // Reset in the middle of a dump
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (4) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        content_modified = 1'b0;
        tick();
        chk("mrst_ctl", 32'({busy, done, cpu_hold, s_ready, m_valid, ext_eep_data_wr,
                             ext_eep_data_rd, ext_eep_data_en}), 32'h0);
        chk("mrst_cnt", 32'(byte_cnt), 32'h0);
        chk("mrst_addr", 32'(ext_eep_addr), 32'h0);
        chk("mrst_mdata", 32'(m_data), 32'h0);
        chk("mrst_dout", 32'(ext_eep_data_out), 32'h0);
        done0 = done_cnt;
        rst = 1'b0;
        repeat (3) tick();
        chk("mrst_no_done", done_cnt - done0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
